// File: rtl/axi_ad7124_aux_seq.sv
// AD7124 auxiliary control: staggered per-channel power-up, immediate power-down,
// and relay switching followed by a settle window that holds off ADC data.
module axi_ad7124_aux_seq #(
    parameter int ID                  = 0,
    parameter int NUM_CH              = 4,
    parameter int PWR_STAGGER_CYCLES  = 50000,
    parameter int RELAY_SETTLE_CYCLES = 100000
) (
    input  logic              up_clk,
    input  logic              up_rst,
    input  logic              up_wreq,
    input  logic [13:0]       up_waddr,
    input  logic [31:0]       up_wdata,
    output logic              up_wack,
    input  logic              up_rreq,
    input  logic [13:0]       up_raddr,
    output logic [31:0]       up_rdata,
    output logic              up_rack,
    output logic [NUM_CH-1:0] ctrl_power_en,
    output logic [NUM_CH-1:0] ctrl_relay_ctrl,
    output logic              ctrl_adc_hold
);
    localparam int          PCW     = $clog2(PWR_STAGGER_CYCLES + 1);
    localparam int          RCW     = $clog2(RELAY_SETTLE_CYCLES + 1);
    localparam logic [31:0] VERSION = 32'h20210301;

    typedef enum logic {P_IDLE, P_WAIT}   pwr_state_t;
    typedef enum logic {R_IDLE, R_SETTLE} relay_state_t;

    logic [31:0]       scratch;
    logic [NUM_CH-1:0] pwr_req;
    logic [NUM_CH-1:0] relay_req;
    logic [NUM_CH-1:0] pwr_act;
    logic [NUM_CH-1:0] pwr_act_nxt;
    logic [NUM_CH-1:0] relay_act;
    logic [NUM_CH-1:0] relay_act_nxt;
    logic [NUM_CH-1:0] pwr_up;
    pwr_state_t        pstate;
    pwr_state_t        pstate_nxt;
    relay_state_t      rstate;
    relay_state_t      rstate_nxt;
    logic [PCW-1:0]    pcnt;
    logic [PCW-1:0]    pcnt_nxt;
    logic [RCW-1:0]    rcnt;
    logic [RCW-1:0]    rcnt_nxt;
    logic              pwr_busy;
    logic              relay_busy;
    logic [31:0]       rd_mux;

    assign pwr_up     = pwr_req & ~pwr_act;
    assign pwr_busy   = (pstate == P_WAIT) || (pwr_up != '0);
    assign relay_busy = (rstate == R_SETTLE) || (relay_req != relay_act);

    // Dropped requests clear every cycle; only one channel is added per stagger window.
    always_comb begin
        pstate_nxt  = pstate;
        pcnt_nxt    = pcnt;
        pwr_act_nxt = pwr_act & pwr_req;
        case (pstate)
            P_IDLE: begin
                if (pwr_up != '0) begin
                    pwr_act_nxt = (pwr_act & pwr_req) | (pwr_up & (~pwr_up + NUM_CH'(1)));
                    pcnt_nxt    = PCW'(PWR_STAGGER_CYCLES - 1);
                    pstate_nxt  = P_WAIT;
                end
            end
            P_WAIT: begin
                if (pcnt == '0) pstate_nxt = P_IDLE;
                else            pcnt_nxt   = pcnt - PCW'(1);
            end
            default: pstate_nxt = P_IDLE;
        endcase
    end

    always_comb begin
        rstate_nxt    = rstate;
        rcnt_nxt      = rcnt;
        relay_act_nxt = relay_act;
        case (rstate)
            R_IDLE: begin
                if (relay_req != relay_act) begin
                    relay_act_nxt = relay_req;
                    rcnt_nxt      = RCW'(RELAY_SETTLE_CYCLES - 1);
                    rstate_nxt    = R_SETTLE;
                end
            end
            R_SETTLE: begin
                if (rcnt == '0) rstate_nxt = R_IDLE;
                else            rcnt_nxt   = rcnt - RCW'(1);
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (up_raddr)
            14'h00: rd_mux = VERSION;
            14'h01: rd_mux = 32'(ID);
            14'h02: rd_mux = scratch;
            14'h03: rd_mux = {16'h0, 8'(RELAY_SETTLE_CYCLES > 0), 8'(NUM_CH)};
            14'h10: rd_mux[NUM_CH-1:0] = pwr_req;
            14'h11: rd_mux[NUM_CH-1:0] = relay_req;
            14'h12: rd_mux = {30'h0, relay_busy, pwr_busy};
            14'h13: rd_mux[NUM_CH-1:0] = pwr_act;
            14'h14: rd_mux[NUM_CH-1:0] = relay_act;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            up_wack   <= 1'b0;
            up_rack   <= 1'b0;
            up_rdata  <= '0;
            scratch   <= '0;
            pwr_req   <= '0;
            relay_req <= '0;
            pwr_act   <= '0;
            relay_act <= '0;
            pstate    <= P_IDLE;
            rstate    <= R_IDLE;
            pcnt      <= '0;
            rcnt      <= '0;
        end else begin
            up_wack <= up_wreq;
            up_rack <= up_rreq;
            if (up_rreq) up_rdata <= rd_mux;
            if (up_wreq) begin
                case (up_waddr)
                    14'h02:  scratch   <= up_wdata;
                    14'h10:  pwr_req   <= up_wdata[NUM_CH-1:0];
                    14'h11:  relay_req <= up_wdata[NUM_CH-1:0];
                    default: ;
                endcase
            end
            pwr_act   <= pwr_act_nxt;
            relay_act <= relay_act_nxt;
            pstate    <= pstate_nxt;
            rstate    <= rstate_nxt;
            pcnt      <= pcnt_nxt;
            rcnt      <= rcnt_nxt;
        end
    end

    assign ctrl_power_en   = pwr_act;
    assign ctrl_relay_ctrl = relay_act;
    assign ctrl_adc_hold   = relay_busy;

endmodule
